// File: rtl/types_pkg.sv
// types_pkg: shared reorder-buffer constants and entry/completion record types.
package types_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = 4;
    localparam int PREG_W    = 7;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_pd;
        logic              is_branch;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] pd_old;
    } rob_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic                 mispredict;
    } rob_cmpl_t;

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement queue returning old pregs to the free list and raising branch flushes.
module reorder_buffer
    import types_pkg::rob_entry_t, types_pkg::rob_cmpl_t;
#(
    parameter int DEPTH  = types_pkg::ROB_DEPTH,
    parameter int TAG_W  = types_pkg::ROB_TAG_W,
    parameter int PREG_W = types_pkg::PREG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [TAG_W-1:0]  alloc_rob_tag,
    input  logic              alloc_has_pd,
    input  logic [PREG_W-1:0] alloc_pd_new,
    input  logic [PREG_W-1:0] alloc_pd_old,
    input  logic              alloc_is_branch,
    input  logic              cmpl_valid,
    input  logic [TAG_W-1:0]  cmpl_rob_tag,
    input  logic              cmpl_mispredict,
    output logic              free_en,
    output logic [PREG_W-1:0] free_preg,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_rob_tag,
    output logic              mispredict,
    output logic [TAG_W-1:0]  mispredict_tag,
    output logic              empty
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0] ONE  = (TAG_W+1)'(1);

    rob_entry_t        rob [DEPTH];
    rob_cmpl_t         cmpl;
    logic [TAG_W-1:0]  head, tail, b_off;
    logic [TAG_W:0]    count, count_n, ret_w, alloc_w;
    logic [DEPTH-1:0]  squash;
    logic              cmpl_hit, flush, ret, alloc_fire, ret_free;
    logic [PREG_W-1:0] unused_pd;
    logic              unused_ok;

    // Entries strictly younger than the branch, measured as distance from head.
    function automatic logic [DEPTH-1:0] young_mask(input logic [TAG_W-1:0] h, input logic [TAG_W-1:0] b);
        logic [DEPTH-1:0] m;
        logic [TAG_W-1:0] off;
        logic [TAG_W-1:0] boff;
        boff = b - h;
        for (int i = 0; i < DEPTH; i++) begin
            off  = TAG_W'(i) - h;
            m[i] = off > boff;
        end
        return m;
    endfunction

    assign cmpl        = '{valid: cmpl_valid, tag: cmpl_rob_tag, mispredict: cmpl_mispredict};
    assign cmpl_hit    = cmpl.valid && rob[cmpl.tag].valid;
    assign flush       = cmpl_hit && cmpl.mispredict && rob[cmpl.tag].is_branch;
    assign ret         = rob[head].valid && rob[head].done;
    assign ret_free    = ret && rob[head].has_pd && (rob[head].pd_old != '0);
    assign alloc_ready = (count != FULL) && !mispredict;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign b_off       = cmpl.tag - head;
    assign ret_w       = {{TAG_W{1'b0}}, ret};
    assign alloc_w     = {{TAG_W{1'b0}}, alloc_fire};
    assign squash      = young_mask(head, cmpl.tag);
    // A flush keeps head..branch inclusive; a same-cycle retire removes one of those.
    assign count_n     = flush ? {1'b0, b_off} + ONE - ret_w : count + alloc_w - ret_w;

    always_comb begin
        unused_pd = '0;
        for (int i = 0; i < DEPTH; i++) unused_pd = unused_pd ^ rob[i].pd_new;
        unused_ok = ^{alloc_rob_tag, unused_pd};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob[i].valid <= 1'b0;
                rob[i].done  <= 1'b0;
            end
            free_en        <= 1'b0;
            free_preg      <= '0;
            commit_valid   <= 1'b0;
            commit_rob_tag <= '0;
            mispredict     <= 1'b0;
            mispredict_tag <= '0;
            empty          <= 1'b1;
        end else begin
            if (alloc_fire)
                rob[tail] <= '{valid: 1'b1, done: 1'b0, has_pd: alloc_has_pd, is_branch: alloc_is_branch,
                               pd_new: alloc_pd_new, pd_old: alloc_pd_old};
            if (cmpl_hit)
                rob[cmpl.tag].done <= 1'b1;
            for (int i = 0; i < DEPTH; i++)
                if (flush && squash[i]) rob[i].valid <= 1'b0;
            if (ret)
                rob[head].valid <= 1'b0;
            head           <= ret ? head + 1'b1 : head;
            tail           <= flush ? cmpl.tag + 1'b1 : (alloc_fire ? tail + 1'b1 : tail);
            count          <= count_n;
            commit_valid   <= ret;
            commit_rob_tag <= ret ? head : commit_rob_tag;
            free_en        <= ret_free;
            free_preg      <= ret_free ? rob[head].pd_old : '0;
            mispredict     <= flush;
            mispredict_tag <= flush ? cmpl.tag : mispredict_tag;
            empty          <= count_n == '0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scoreboard bench for the reorder buffer.
module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [3:0] alloc_rob_tag = '0;
    logic       alloc_has_pd = 1'b0;
    logic [6:0] alloc_pd_new = '0;
    logic [6:0] alloc_pd_old = '0;
    logic       alloc_is_branch = 1'b0;
    logic       cmpl_valid = 1'b0;
    logic [3:0] cmpl_rob_tag = '0;
    logic       cmpl_mispredict = 1'b0;
    logic       free_en;
    logic [6:0] free_preg;
    logic       commit_valid;
    logic [3:0] commit_rob_tag;
    logic       mispredict;
    logic [3:0] mispredict_tag;
    logic       empty;

    typedef struct {
        logic [3:0] tag;
        logic       fe;
        logic [6:0] fp;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_tail = '0;
    int         passed = 0;
    int         total = 0;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_tag(alloc_rob_tag),
        .alloc_has_pd(alloc_has_pd), .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
        .alloc_is_branch(alloc_is_branch),
        .cmpl_valid(cmpl_valid), .cmpl_rob_tag(cmpl_rob_tag), .cmpl_mispredict(cmpl_mispredict),
        .free_en(free_en), .free_preg(free_preg),
        .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    // One clock; any retirement seen is matched against the oldest expected commit.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (commit_valid) begin
            if (sb.size() == 0) chk("commit_with_nothing_expected", {31'b0, commit_valid}, 32'd0);
            else begin
                e = sb.pop_front();
                chk("commit_rob_tag", {28'b0, commit_rob_tag}, {28'b0, e.tag});
                chk("free_en", {31'b0, free_en}, {31'b0, e.fe});
                chk("free_preg", {25'b0, free_preg}, {25'b0, e.fp});
            end
        end else chk("free_en_idle", {31'b0, free_en}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_alloc(input logic hp, input logic [6:0] pn, input logic [6:0] po, input logic br);
        exp_t e;
        chk("alloc_ready_before_alloc", {31'b0, alloc_ready}, 32'd1);
        alloc_valid = 1'b1;
        alloc_rob_tag = exp_tail;
        alloc_has_pd = hp;
        alloc_pd_new = pn;
        alloc_pd_old = po;
        alloc_is_branch = br;
        e.tag = exp_tail;
        e.fe = hp && (po != 7'd0);
        e.fp = e.fe ? po : 7'd0;
        sb.push_back(e);
        exp_tail = exp_tail + 4'd1;
        cyc();
        alloc_valid = 1'b0;
        alloc_is_branch = 1'b0;
    endtask

    task automatic do_cmpl(input logic [3:0] tag, input logic mp);
        cmpl_valid = 1'b1;
        cmpl_rob_tag = tag;
        cmpl_mispredict = mp;
        cyc();
        cmpl_valid = 1'b0;
        cmpl_mispredict = 1'b0;
    endtask

    task automatic rst_dut();
        alloc_valid = 1'b0;
        cmpl_valid = 1'b0;
        cmpl_mispredict = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_tail = '0;
        chk("reset_empty", {31'b0, empty}, 32'd1);
        chk("reset_alloc_ready", {31'b0, alloc_ready}, 32'd1);
        chk("reset_commit_valid", {31'b0, commit_valid}, 32'd0);
        chk("reset_mispredict", {31'b0, mispredict}, 32'd0);
    endtask

    initial begin
        // Reset and idle
        rst_dut();
        chk("reset_free_preg", {25'b0, free_preg}, 32'd0);
        chk("reset_commit_tag", {28'b0, commit_rob_tag}, 32'd0);
        chk("reset_mispredict_tag", {28'b0, mispredict_tag}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_empty", {31'b0, empty}, 32'd1);
            chk("idle_alloc_ready", {31'b0, alloc_ready}, 32'd1);
            chk("idle_mispredict", {31'b0, mispredict}, 32'd0);
        end

        // Out-of-order completion, in-order retirement
        do_alloc(1'b1, 7'd40, 7'd33, 1'b0);
        do_alloc(1'b1, 7'd41, 7'd34, 1'b0);
        do_alloc(1'b1, 7'd42, 7'd35, 1'b0);
        chk("empty_after_alloc", {31'b0, empty}, 32'd0);
        do_cmpl(4'd2, 1'b0);
        chk("no_retire_tag2_first", {31'b0, commit_valid}, 32'd0);
        cyc();
        chk("no_retire_before_head", {31'b0, commit_valid}, 32'd0);
        do_cmpl(4'd0, 1'b0);
        chk("no_retire_same_cycle", {31'b0, commit_valid}, 32'd0);
        do_cmpl(4'd1, 1'b0);
        chk("retire0", {31'b0, commit_valid}, 32'd1);
        cyc();
        chk("retire1_consecutive", {31'b0, commit_valid}, 32'd1);
        cyc();
        chk("retire2_consecutive", {31'b0, commit_valid}, 32'd1);
        cyc();
        chk("drain_order", sb.size(), 32'd0);
        chk("drain_empty", {31'b0, empty}, 32'd1);

        // Full buffer and tag wrap
        rst_dut();
        for (int i = 0; i < 16; i++) do_alloc(1'b1, 7'(60 + i), 7'(20 + i), 1'b0);
        chk("full_alloc_ready", {31'b0, alloc_ready}, 32'd0);
        chk("full_not_empty", {31'b0, empty}, 32'd0);
        do_cmpl(4'd0, 1'b0);
        chk("full_still_blocked", {31'b0, alloc_ready}, 32'd0);
        cyc();
        chk("ready_after_retire", {31'b0, alloc_ready}, 32'd1);
        chk("wrap_tag_is_zero", {28'b0, exp_tail}, 32'd0);
        do_alloc(1'b1, 7'd90, 7'd45, 1'b0);
        chk("full_again", {31'b0, alloc_ready}, 32'd0);
        for (int i = 1; i < 16; i++) do_cmpl(4'(i), 1'b0);
        do_cmpl(4'd0, 1'b0);
        idle(3);
        chk("wrap_drain", sb.size(), 32'd0);
        do_alloc(1'b1, 7'd91, 7'd46, 1'b0);
        do_cmpl(4'd1, 1'b0);
        idle(2);
        chk("wrap_tail_tag1", sb.size(), 32'd0);
        chk("wrap_empty", {31'b0, empty}, 32'd1);

        // Branch mispredict flush
        rst_dut();
        for (int i = 0; i < 7; i++) do_alloc(i != 3, 7'(40 + i), 7'(10 + i), i == 3);
        cmpl_valid = 1'b1;
        cmpl_rob_tag = 4'd3;
        cmpl_mispredict = 1'b1;
        alloc_valid = 1'b1;
        alloc_rob_tag = 4'd7;
        alloc_has_pd = 1'b1;
        alloc_pd_old = 7'd99;
        cyc();
        cmpl_valid = 1'b0;
        cmpl_mispredict = 1'b0;
        alloc_valid = 1'b0;
        chk("mispredict_pulse", {31'b0, mispredict}, 32'd1);
        chk("mispredict_tag", {28'b0, mispredict_tag}, 32'd3);
        chk("flush_blocks_alloc", {31'b0, alloc_ready}, 32'd0);
        while (sb.size() > 0 && sb[$].tag != 4'd3) void'(sb.pop_back());
        exp_tail = 4'd4;
        cyc();
        chk("mispredict_one_cycle", {31'b0, mispredict}, 32'd0);
        chk("ready_after_flush", {31'b0, alloc_ready}, 32'd1);
        do_cmpl(4'd5, 1'b1);
        chk("squashed_cmpl_ignored", {31'b0, mispredict}, 32'd0);
        do_alloc(1'b1, 7'd50, 7'd17, 1'b0);
        do_alloc(1'b1, 7'd51, 7'd18, 1'b0);
        do_cmpl(4'd0, 1'b0);
        do_cmpl(4'd1, 1'b0);
        do_cmpl(4'd2, 1'b0);
        do_cmpl(4'd4, 1'b0);
        idle(4);
        chk("tag5_still_pending", sb.size(), 32'd1);
        chk("tag5_not_empty", {31'b0, empty}, 32'd0);
        do_cmpl(4'd5, 1'b0);
        idle(2);
        chk("flush_drain", sb.size(), 32'd0);
        chk("flush_empty", {31'b0, empty}, 32'd1);

        // Store and x0-old entries retire without freeing
        rst_dut();
        do_alloc(1'b0, 7'd0, 7'd25, 1'b0);
        do_alloc(1'b1, 7'd30, 7'd0, 1'b0);
        do_cmpl(4'd0, 1'b0);
        do_cmpl(4'd1, 1'b0);
        chk("store_commit", {31'b0, commit_valid}, 32'd1);
        cyc();
        chk("pd0_commit", {31'b0, commit_valid}, 32'd1);
        idle(1);
        chk("nofree_drain", sb.size(), 32'd0);

        // Reset mid-operation
        rst_dut();
        for (int i = 0; i < 9; i++) do_alloc(1'b1, 7'(70 + i), 7'(100 + i), 1'b0);
        do_cmpl(4'd2, 1'b0);
        do_cmpl(4'd4, 1'b0);
        do_cmpl(4'd6, 1'b0);
        rst_dut();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("post_reset_no_commit", {31'b0, commit_valid}, 32'd0);
        end
        do_cmpl(4'd0, 1'b0);
        cyc();
        chk("stale_cmpl_no_commit", {31'b0, commit_valid}, 32'd0);
        chk("stale_empty", {31'b0, empty}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
